keypad_matrix_emulator: RTL

- Synthesizable model of the physical 4x4 membrane keypad on the other end of the vending machine's column-scan/row-sense interface.
- Watches the active-low column strobes (shift_col) driven by the scanner and pulls the matching active-low row line while a virtual key is closed.
- A press is requested by a bench or test sequencer via a req/busy/done handshake, with programmable hold time.
- Contact bounce is generated on both press and release so the scanner's debounce logic is exercised in simulation and in on-board self-test.

---
 rtl/keypad_matrix_emulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator
// Behavioural stand-in for a 4x4 membrane keypad on a column-scan/row-sense
// bus. A sequencer requests a key press through req/busy/done. The emulated
// switch chatters pseudo-randomly on make and on break, holds closed for a
// programmable time, and pulls its row line low only while its column strobe
// is active.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// IDLE           | switch open, waiting for req; key/hold latched on req
// PRESS_BOUNCE   | contact follows LFSR chatter for BOUNCE_CYCLES cycles
// HOLD           | contact solidly closed for the latched hold count
// RELEASE_BOUNCE | contact follows LFSR chatter for BOUNCE_CYCLES cycles
// DONE           | switch open, one-cycle done pulse, then back to IDLE
module keypad_matrix_emulator #(
  parameter int          BOUNCE_CYCLES = 8,
  parameter int          HOLD_W        = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [3:0]        key,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [3:0]        shift_col,
  output logic [3:0]        row,
  output logic              busy,
  output logic              done,
  output logic              contact
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int BCW = (BOUNCE_CYCLES < 2) ? 1 : $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BCW-1:0] B_LOAD = BCW'(BOUNCE_CYCLES);
  localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESS_BOUNCE   = 3'd1,
    HOLD           = 3'd2,
    RELEASE_BOUNCE = 3'd3,
    DONE           = 3'd4
  } state_t;

  state_t            state_q;
  logic              contact_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        key_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [BCW-1:0]    bnc_cnt_q;
  logic [7:0]        lfsr_q;
  logic [7:0]        lfsr_d;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Press sequencer; all outputs registered from the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      contact_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      key_q      <= 4'h0;
      hold_cnt_q <= '0;
      bnc_cnt_q  <= '0;
      lfsr_q     <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          contact_q <= 1'b0;
          if (req) begin
            key_q      <= key;
            // A zero hold would never reach terminal count; treat it as one.
            hold_cnt_q <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
            bnc_cnt_q  <= B_LOAD;
            state_q    <= NO_BOUNCE ? HOLD : PRESS_BOUNCE;
          end
        end
        PRESS_BOUNCE: begin
          contact_q <= lfsr_q[0];
          if (bnc_cnt_q == BCW'(1)) begin
            state_q <= HOLD;
          end else begin
            bnc_cnt_q <= bnc_cnt_q - BCW'(1);
          end
        end
        HOLD: begin
          contact_q <= 1'b1;
          if (hold_cnt_q == HOLD_W'(1)) begin
            bnc_cnt_q <= B_LOAD;
            state_q   <= NO_BOUNCE ? DONE : RELEASE_BOUNCE;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        RELEASE_BOUNCE: begin
          contact_q <= lfsr_q[0];
          if (bnc_cnt_q == BCW'(1)) begin
            state_q <= DONE;
          end else begin
            bnc_cnt_q <= bnc_cnt_q - BCW'(1);
          end
        end
        DONE: begin
          contact_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          contact_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency switch path: the closed key pulls its row while its column is strobed.
  always_comb begin
    row = 4'hF;
    if (contact_q && !shift_col[key_q[3:2]]) begin
      row[key_q[1:0]] = 1'b0;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign contact = contact_q;

endmodule
